imem_arbiter: RTL

//   Shares the single-port synchronous instruction memory between the fetch stage (read-only, every cycle)
//   and the program loader/debug port (read or write). Fetch has priority; a starvation counter forces

---
 rtl/imem_arbiter_if.sv | 39 +++
 rtl/imem_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// Bundles the fetch, loader and RAM-side signals of the instruction-memory arbiter.
// Latency: none (wires only); read data returns one cycle after the RAM access.
// Backpressure: fetch sees fe_stall and the loader waits for ld_gnt; neither side is ever dropped.
// Ports: slave = arbiter view, master = client/RAM-side view (fetch, loader, memory).
interface imem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              fe_req;
    logic [ADDR_W-1:0] fe_addr;
    logic              fe_stall;
    logic [31:0]       fe_rdata;
    logic              fe_rvalid;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_gnt;
    logic [31:0]       ld_rdata;
    logic              ld_rvalid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  fe_req, fe_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        output fe_stall, fe_rdata, fe_rvalid, ld_gnt, ld_rdata, ld_rvalid,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fe_req, fe_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        input  fe_stall, fe_rdata, fe_rvalid, ld_gnt, ld_rdata, ld_rvalid,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares a single-port sync instruction RAM between fetch (priority) and the loader/debug port.
// Latency: grant is combinational in the request cycle; read data returns the following cycle.
// Backpressure: refused fetch sees fe_stall; loader holds ld_req until ld_gnt, with bounded wait/burst.
// Ports: clk, rst_n (async active-low), bus (imem_arbiter_if.slave: fetch, loader and RAM signals).
module imem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 4,
    parameter int LD_BURST = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_arbiter_if.slave  bus
);
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(LD_BURST + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(LD_BURST);

    localparam logic [0:0] FE_PRI = 1'b0;
    localparam logic [0:0] LD_PRI = 1'b1;

    logic [0:0]         state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic               fe_rvalid;
    logic               ld_rvalid;

    logic ld_prio;
    logic ld_gnt;
    logic fe_gnt;

    // Loader wins when its burst is still open, when it has waited long enough,
    // or when an exhausted burst has no competing fetch.
    always_comb begin
        ld_prio = ((state == LD_PRI) && (burst_cnt < BURST_MAX))
               || ((state == FE_PRI) && (wait_cnt == WAIT_MAX))
               || ((state == LD_PRI) && (burst_cnt == BURST_MAX) && !bus.fe_req);
    end

    // rst_n gates the grants so the RAM is never touched while reset is held.
    assign ld_gnt = rst_n && bus.ld_req && (ld_prio || !bus.fe_req);
    assign fe_gnt = rst_n && bus.fe_req && !ld_gnt;

    assign bus.ld_gnt    = ld_gnt;
    assign bus.fe_stall  = bus.fe_req && !fe_gnt;
    assign bus.mem_en    = fe_gnt || ld_gnt;
    assign bus.mem_we    = ld_gnt && bus.ld_we;
    assign bus.mem_addr  = ld_gnt ? bus.ld_addr : bus.fe_addr;
    assign bus.mem_wdata = bus.ld_wdata;

    assign bus.fe_rvalid = fe_rvalid;
    assign bus.ld_rvalid = ld_rvalid;
    assign bus.fe_rdata  = fe_rvalid ? bus.mem_rdata : 32'd0;
    assign bus.ld_rdata  = ld_rvalid ? bus.mem_rdata : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FE_PRI;
            wait_cnt  <= '0;
            burst_cnt <= '0;
            fe_rvalid <= 1'b0;
            ld_rvalid <= 1'b0;
        end else begin
            fe_rvalid <= fe_gnt;
            ld_rvalid <= ld_gnt && !bus.ld_we;

            case (state)
                FE_PRI: begin
                    if (ld_gnt && (wait_cnt == WAIT_MAX)) begin
                        // The grant that opens the burst counts as its first.
                        state     <= LD_PRI;
                        burst_cnt <= BURST_W'(1);
                        wait_cnt  <= '0;
                    end else if (bus.ld_req && !ld_gnt) begin
                        if (wait_cnt < WAIT_MAX)
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                LD_PRI: begin
                    if (!bus.ld_req || fe_gnt) begin
                        state     <= FE_PRI;
                        burst_cnt <= '0;
                        wait_cnt  <= '0;
                    end else begin
                        if (ld_gnt && (burst_cnt < BURST_MAX))
                            burst_cnt <= burst_cnt + BURST_W'(1);
                        if (ld_gnt)
                            wait_cnt <= '0;
                        else if (wait_cnt < WAIT_MAX)
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state     <= FE_PRI;
                    burst_cnt <= '0;
                    wait_cnt  <= '0;
                end
            endcase
        end
    end
endmodule
